// File: rtl/complete_arbiter_pkg.sv
// Shared types and sizing for the completion arbiter: physical tag, ROB
// completion packet and default requester count.
package complete_arbiter_pkg;

  localparam int unsigned ROB_SZ      = 32;
  localparam int unsigned ROB_IDX_W   = $clog2(ROB_SZ);
  localparam int unsigned PHYS_REGS   = 64;
  localparam int unsigned NUM_REQ_DEF = 4;

  typedef logic [$clog2(PHYS_REGS)-1:0] TAG;

  typedef struct packed {
    logic                 complete_en;
    logic [ROB_IDX_W-1:0] complete_idx;
  } IC_ROB_PACKET;

endpackage

// File: rtl/complete_arbiter_if.sv
// Completion bus: functional-unit requests in, ROB packet and CDB broadcast out.
interface complete_arbiter_if
  import complete_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned IDX_W   = ROB_IDX_W
) ();

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0][IDX_W-1:0] req_rob_idx;
  TAG   [NUM_REQ-1:0]            req_tag;
  logic [NUM_REQ-1:0]            req_ready;
  IC_ROB_PACKET                  ic_rob_packet;
  logic                          cdb_valid;
  TAG                            cdb_tag;

  modport master (
    output req_valid, req_rob_idx, req_tag,
    input  req_ready, ic_rob_packet, cdb_valid, cdb_tag
  );

  modport slave (
    input  req_valid, req_rob_idx, req_tag,
    output req_ready, ic_rob_packet, cdb_valid, cdb_tag
  );

endinterface

// File: rtl/complete_arbiter_rr_arbiter.sv
// Round-robin selector: first set request at or after ptr, wrapping, wins.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic             found;
  logic [PTR_W-1:0] sel;

  always_comb begin
    grant = '0;
    found = 1'b0;
    sel   = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      sel = PTR_W'((32'(ptr) + off) % NUM_REQ);
      if (!found && req[sel]) begin
        grant[sel] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/complete_arbiter.sv
// Completion arbiter: grants one functional unit per cycle round-robin and
// registers its ROB index and tag onto the ROB packet and CDB.
module complete_arbiter
  import complete_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned IDX_W   = ROB_IDX_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               interrupt,
  complete_arbiter_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               en_q, en_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  TAG                 tag_q, tag_d;
  logic [NUM_REQ-1:0] rr_grant, grant;
  logic [PTR_W-1:0]   gnt_idx;
  logic               transfer;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req   (bus.req_valid),
    .ptr   (ptr_q),
    .grant (rr_grant)
  );

  always_comb begin
    grant    = interrupt ? '0 : rr_grant;
    transfer = |(grant & bus.req_valid);
    gnt_idx  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) gnt_idx = PTR_W'(i);
    end

    ptr_d = ptr_q;
    en_d  = transfer;
    idx_d = idx_q;
    tag_d = tag_q;
    // flush wipes the registered stage as well as the pointer
    if (interrupt) begin
      ptr_d = '0;
      en_d  = 1'b0;
      idx_d = '0;
      tag_d = '0;
    end else if (transfer) begin
      ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
      idx_d = bus.req_rob_idx[gnt_idx];
      tag_d = bus.req_tag[gnt_idx];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
      en_q  <= 1'b0;
      idx_q <= '0;
      tag_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      en_q  <= en_d;
      idx_q <= idx_d;
      tag_q <= tag_d;
    end
  end

  assign bus.req_ready                  = grant;
  assign bus.ic_rob_packet.complete_en  = en_q;
  assign bus.ic_rob_packet.complete_idx = ROB_IDX_W'(idx_q);
  assign bus.cdb_valid                  = en_q;
  assign bus.cdb_tag                    = tag_q;

endmodule

// File: doc/complete_arbiter.md
COMPLETE_ARBITER -- requirements
Module: complete_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of functional-unit completion requesters (legal range 2..8).
REQ-002 Parameter IDX_W, default $clog2(`ROB_SZ), SHALL set the width of a ROB entry index.
REQ-003 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset (asserted at 0).
REQ-005 interrupt  input  1  SHALL be the synchronous flush; same effect as reset, taken at the next rising edge.
REQ-006 req_valid  input  NUM_REQ  SHALL flag a pending completion per requester.
REQ-007 req_rob_idx  input  NUM_REQ x IDX_W  SHALL carry the ROB index of each requester's completing instruction.
REQ-008 req_tag  input  NUM_REQ x TAG  SHALL carry the destination physical tag of each completing instruction.
REQ-009 req_ready  output  NUM_REQ  SHALL be the one-hot (or zero) grant; a requester's transfer occurs when req_valid[i] and req_ready[i] are both 1.
REQ-010 ic_rob_packet  output  IC_ROB_PACKET  SHALL drive complete_en and complete_idx to the ROB.
REQ-011 cdb_valid  output  1  SHALL flag a valid tag broadcast.
REQ-012 cdb_tag  output  TAG  SHALL carry the broadcast physical tag.

Function
REQ-013 req_ready SHALL be combinational from req_valid, the priority pointer and interrupt; at most one bit set per cycle.
REQ-014 Grant SHALL be round-robin: search starts at priority pointer p, first i in order p, p+1, ..., NUM_REQ-1, 0, ..., p-1 with req_valid[i]=1 wins.
REQ-015 After a transfer by requester g, p SHALL become (g+1) mod NUM_REQ; with no transfer, p SHALL hold.
REQ-016 A granted request SHALL appear registered on outputs one cycle later: complete_en=1, complete_idx=req_rob_idx[g], cdb_valid=1, cdb_tag=req_tag[g]; latency exactly 1 cycle.
REQ-017 With no transfer in a cycle, next-cycle complete_en and cdb_valid SHALL be 0; complete_idx and cdb_tag hold their previous values.
REQ-018 Throughput SHALL be one completion per cycle, sustained, with no bubble between back-to-back grants.
REQ-019 Requesters SHALL hold valid, rob_idx and tag stable until granted; the arbiter does not buffer ungranted requests.
REQ-020 With interrupt=1, req_ready SHALL be all 0 in that cycle; at the next edge outputs clear and p resets to 0.
REQ-021 A request whose req_valid drops before grant SHALL be discarded, and p SHALL NOT change on its account.
REQ-022 No requester SHALL wait more than NUM_REQ-1 transfers of other requesters once valid (starvation bound).

Reset
REQ-023 While reset=0, p=0, complete_en=0, complete_idx=0, cdb_valid=0, cdb_tag=0 (valid=0), asynchronously.
REQ-024 Reset asserted mid-stream SHALL drop any in-flight registered completion; no completion SHALL appear on the first edge after deassertion unless granted in the cycle before it.

Structure
REQ-025 TAG, IC_ROB_PACKET and the NUM_REQ default SHALL be defined in the shared package; no new typedefs are local to the module.
REQ-026 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req vector, pointer; output one-hot grant), instantiated once.

Verification
REQ-027 Reset, then valid=4'b0000 for 5 cycles -> req_ready=0, complete_en=0, cdb_valid=0 throughout.
REQ-028 p=0, valid=4'b1111 held 8 cycles -> grants 0,1,2,3,0,1,2,3; complete_en=1 from cycle 2 on, with complete_idx matching each granted req_rob_idx one cycle later.
REQ-029 p=2, valid=4'b0011 -> grant requester 0 (wraps past 2,3), p becomes 1; next cycle grant requester 1.
REQ-030 Requester 1 idx=5, tag=9 granted in the same cycle interrupt=1 -> req_ready=0, no completion next cycle, p=0.
REQ-031 reset pulsed low for 1 cycle while complete_en=1 -> complete_en and cdb_valid drop to 0 immediately, without waiting for a clock edge.
REQ-032 Requester 3 valid continuously while 0..2 toggle randomly for 100 cycles -> requester 3 granted within 3 transfers of each assertion; one grant per cycle maximum.
